// File: rtl/rr_mux_pkg.sv
// Shared constants for the round-robin stream multiplexer.
// Optional build macro RR_MUX_STATS_EN adds a saturating handshake counter
// whose width is STATS_W.
package rr_mux_pkg;

  // Selection policy carried on the mode input.
  localparam logic MODE_RR    = 1'b0;  // rotate fairly among valid channels
  localparam logic MODE_FIXED = 1'b1;  // take only the channel named by sel

  // Width of the optional transfer counter.
  localparam int STATS_W = 16;

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// Combinational rotating-priority arbiter for rr_stream_mux.
// Highest priority goes to the request at index ptr. Priority then falls
// through ptr+1, ptr+2, ... and wraps past NUM_CH-1 back to 0. The grant is
// returned both one-hot and as an index. The caller owns the pointer.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);

  // Rotate the request vector so bit 0 is the channel at ptr.
  logic [2*NUM_CH-1:0] req_dbl;
  logic [NUM_CH-1:0]   req_rot;

  // Rotation by shifting a doubled copy of the request vector.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[NUM_CH-1:0];
  end

  // Pick the first rotated request, then map its offset back to an absolute
  // index. The sum is one bit wider so the wrap test cannot overflow.
  logic              found;
  logic [SEL_W:0]    abs_idx;

  // First-set search over the rotated requests.
  always_comb begin
    found     = 1'b0;
    abs_idx   = '0;
    grant     = '0;
    grant_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && req_rot[k]) begin
        found   = 1'b1;
        abs_idx = {1'b0, ptr} + (SEL_W+1)'(k);
        if (abs_idx >= (SEL_W+1)'(NUM_CH)) begin
          abs_idx = abs_idx - (SEL_W+1)'(NUM_CH);
        end
      end
    end
    if (found) begin
      grant_idx        = abs_idx[SEL_W-1:0];
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel stream multiplexer with a registered output stage.
// Grants one input channel per cycle, either round-robin or by a
// software-driven select, and registers the accepted beat on a single
// output stream.
// Optional build macro: RR_MUX_STATS_EN adds the xfer_cnt output, a
// saturating count of output handshakes.
//
// Handshake rule on every stream: a beat moves on a rising edge where
// valid and ready are both high. Producers hold valid and data steady until
// the beat is accepted. Ready may depend combinationally on valid, but valid
// never depends on ready.
module rr_stream_mux
  import rr_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
`ifdef RR_MUX_STATS_EN
  ,
  output logic [STATS_W-1:0]       xfer_cnt
`endif
);

  // Registered state.
  logic              out_valid_d, out_valid_q;
  logic [DATA_W-1:0] out_data_d,  out_data_q;
  logic [SEL_W-1:0]  out_ch_d,    out_ch_q;
  logic [SEL_W-1:0]  ptr_d,       ptr_q;

  // Arbitration results.
  logic [NUM_CH-1:0] arb_grant;
  logic [SEL_W-1:0]  arb_idx;
  logic [NUM_CH-1:0] fix_grant;
  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;

  // Handshake helpers.
  logic              load_en;
  logic              xfer;
  logic [DATA_W-1:0] grant_data;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Fixed-mode grant: only the selected channel. An out-of-range sel matches
  // no index, so it never grants.
  always_comb begin
    fix_grant = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fix_grant[i] = in_valid[i] && (sel == SEL_W'(i));
    end
  end

  // Choose between the rotating arbiter and the fixed select. The choice
  // follows mode and sel in the same cycle.
  always_comb begin
    if (mode == MODE_FIXED) begin
      grant     = fix_grant;
      grant_idx = sel;
    end else begin
      grant     = arb_grant;
      grant_idx = arb_idx;
    end
  end

  // The output register can take a beat when it is empty or being drained.
  // Ready is suppressed during reset so no beat is accepted and then lost.
  always_comb begin
    load_en  = !out_valid_q || out_ready;
    xfer     = load_en && !rst && (|grant);
    in_ready = (load_en && !rst) ? grant : '0;
  end

  // One-hot data select driven by the grant vector.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        grant_data = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic for the output register and the round-robin pointer.
  // Data and channel hold their last values when the register empties.
  // The pointer moves only on round-robin transfers.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = grant_data;
        out_ch_d   = grant_idx;
        if (mode == MODE_RR) begin
          ptr_d = (grant_idx == SEL_W'(NUM_CH-1)) ? '0 : grant_idx + SEL_W'(1);
        end
      end
    end
  end

  // State register. Synchronous reset discards any held beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

`ifdef RR_MUX_STATS_EN
  logic [STATS_W-1:0] cnt_d, cnt_q;

  // Count output handshakes, sticking at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid_q && out_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + STATS_W'(1);
    end
  end

  // Counter register, cleared with the datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench for rr_stream_mux. A 4-channel instance runs a
// per-cycle vector table, a reset in mid-operation and a random backpressure
// phase. A 3-channel instance covers the out-of-range fixed select.
module tb_rr_stream_mux;
  import rr_mux_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;
  localparam int W      = SEL_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- 4-channel DUT ----------------
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_ready;
`ifdef RR_MUX_STATS_EN
  logic [STATS_W-1:0]       xfer_cnt;
`endif

  assign in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

  rr_stream_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
`ifdef RR_MUX_STATS_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  // ---------------- 3-channel DUT ----------------
  logic [2:0]   in3_valid;
  logic [23:0]  in3_data;
  logic [2:0]   in3_ready;
  logic         mode3;
  logic [1:0]   sel3;
  logic         out3_valid;
  logic [7:0]   out3_data;
  logic [1:0]   out3_ch;
  logic         out3_ready;
`ifdef RR_MUX_STATS_EN
  logic [STATS_W-1:0] xfer3_cnt;
`endif

  assign in3_data = {8'hB2, 8'hB1, 8'hB0};

  rr_stream_mux #(.NUM_CH(3), .DATA_W(8)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in3_valid),
    .in_data   (in3_data),
    .in_ready  (in3_ready),
    .mode      (mode3),
    .sel       (sel3),
    .out_valid (out3_valid),
    .out_data  (out3_data),
    .out_ch    (out3_ch),
    .out_ready (out3_ready)
`ifdef RR_MUX_STATS_EN
    ,
    .xfer_cnt  (xfer3_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  // Pop and compare when the DUT hands a beat downstream this cycle.
  task automatic sb_pop();
    logic [W-1:0] e;
    if (out_valid && out_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty actual=%0h expected=none at %0t", {out_ch, out_data}, $time);
      end else begin
        e = exp_q.pop_front();
        chk("sb_beat", 32'({out_ch, out_data}), 32'(e));
      end
    end
  endtask

  // ---------------- driver ----------------
  // Entered and left on a falling edge: drive, check ready, let one rising
  // edge pass, then check the registered outputs.
  task automatic step(input logic [3:0] v, input logic m, input logic [1:0] s,
                      input logic r, input logic [3:0] erdy, input logic ev,
                      input logic [7:0] ed, input logic [1:0] ech, input string tag);
    logic [1:0] gi;
    in_valid  = v;
    mode      = m;
    sel       = s;
    out_ready = r;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(erdy));
    sb_pop();
    if (erdy != 4'b0000) begin
      gi = onehot_idx(erdy);
      exp_q.push_back({gi, 8'hA0 + 8'(gi)});
    end
    @(negedge clk);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".out_data"},  32'(out_data),  32'(ed));
    chk({tag, ".out_ch"},    32'(out_ch),    32'(ech));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] valid;
    logic       mode;
    logic [1:0] sel;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_v;
    logic [7:0] exp_d;
    logic [1:0] exp_ch;
  } vec_t;

  vec_t vecs[25];

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Round-robin at full rate from ptr=0.
    vecs[0]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
    vecs[1]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    vecs[2]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
    vecs[3]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
    vecs[4]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
    // Backpressure for five cycles: output holds, nothing accepted.
    for (int i = 5; i < 10; i++)
      vecs[i] = '{4'hF, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0};
    // Release: resumes with ch1 (ptr=1).
    vecs[10] = '{4'hF, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    // Sparse round-robin from ptr=2 with ch1 and ch3 valid.
    vecs[11] = '{4'hA, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
    vecs[12] = '{4'hA, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    vecs[13] = '{4'hA, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
    // Fixed mode sel=2, then ch2 drops out and the output drains.
    vecs[14] = '{4'hF, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
    vecs[15] = '{4'hF, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
    vecs[16] = '{4'hB, 1'b1, 2'd2, 1'b1, 4'b0000, 1'b0, 8'hA2, 2'd2};
    vecs[17] = '{4'hB, 1'b1, 2'd2, 1'b1, 4'b0000, 1'b0, 8'hA2, 2'd2};
    // Back to round-robin: pointer was held at 0 through fixed mode.
    vecs[18] = '{4'hF, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
    // Select changes while stalled, then takes effect on release.
    vecs[19] = '{4'hF, 1'b1, 2'd3, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0};
    vecs[20] = '{4'hF, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
    // No requests: drain, then idle with data held.
    vecs[21] = '{4'h0, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 8'hA3, 2'd3};
    vecs[22] = '{4'h0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 8'hA3, 2'd3};
    // Empty register loads even with out_ready low; pointer still at 1.
    vecs[23] = '{4'hF, 1'b0, 2'd0, 1'b0, 4'b0010, 1'b1, 8'hA1, 2'd1};
    vecs[24] = '{4'hF, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 8'hA1, 2'd1};

    // Reset for two cycles with every channel requesting.
    rst        = 1'b1;
    in_valid   = 4'hF;
    mode       = MODE_RR;
    sel        = 2'd0;
    out_ready  = 1'b1;
    in3_valid  = 3'b111;
    mode3      = MODE_FIXED;
    sel3       = 2'b11;
    out3_ready = 1'b1;
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'h0);
    chk("rst.out_data",  32'(out_data),  32'h0);
    chk("rst.out_ch",    32'(out_ch),    32'h0);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      step(vecs[i].valid, vecs[i].mode, vecs[i].sel, vecs[i].ordy,
           vecs[i].exp_rdy, vecs[i].exp_v, vecs[i].exp_d, vecs[i].exp_ch,
           $sformatf("vec%0d", i));
    end

    // Reset while a beat is held under backpressure.
    rst       = 1'b1;
    out_ready = 1'b0;
    #1;
    chk("midrst.in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    chk("midrst.out_valid", 32'(out_valid), 32'h0);
    chk("midrst.out_data",  32'(out_data),  32'h0);
    chk("midrst.out_ch",    32'(out_ch),    32'h0);
`ifdef RR_MUX_STATS_EN
    chk("midrst.xfer_cnt",  32'(xfer_cnt),  32'h0);
`endif
    rst = 1'b0;
    exp_q.delete();
    hs_cnt = 0;
    // Pointer back at 0: ch0 wins although ptr was 2 before reset.
    step(4'hF, MODE_RR, 2'd0, 1'b0, 4'b0001, 1'b1, 8'hA0, 2'd0, "postrst");

    // Random backpressure: with every channel valid the beats must come out
    // in strict rotation, none lost or repeated.
    for (int n = 1; n <= 32; n++) begin
      exp_q.push_back({2'(n % 4), 8'hA0 + 8'(n % 4)});
    end
    begin
      int cyc;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 400) begin
        in_valid  = 4'hF;
        mode      = MODE_RR;
        out_ready = 1'($urandom_range(0, 1));
        #1;
        sb_pop();
        @(negedge clk);
        cyc++;
      end
    end
    chk("rand.drained", 32'(exp_q.size()), 32'h0);
`ifdef RR_MUX_STATS_EN
    chk("stats.xfer_cnt", 32'(xfer_cnt), 32'(hs_cnt));
`endif
    out_ready = 1'b0;
    in_valid  = 4'h0;

    // 3-channel instance: sel=3 is out of range and never grants.
    chk("ch3.sel3.in_ready",  32'(in3_ready),  32'h0);
    chk("ch3.sel3.out_valid", 32'(out3_valid), 32'h0);
    sel3 = 2'd2;
    #1;
    chk("ch3.sel2.in_ready", 32'(in3_ready), 32'h4);
    @(negedge clk);
    chk("ch3.sel2.out_valid", 32'(out3_valid), 32'h1);
    chk("ch3.sel2.out_data",  32'(out3_data),  32'hB2);
    chk("ch3.sel2.out_ch",    32'(out3_ch),    32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
